// File: rtl/writeback_stage_if.sv
// Signal bundle between the memory stage, the decode read ports and the
// writeback stage. master drives the pipeline registers, slave is the WB stage.
interface writeback_stage_if;
  logic        WB_V;
  logic [31:0] WB_IR;
  logic [63:0] WB_NPC;
  logic [63:0] WB_ALU_RESULT;
  logic [63:0] WB_MEM_RESULT;
  logic [63:0] WB_CSRFD;
  logic        WB_PC_MUX;
  logic        WB_ECALL;
  logic [4:0]  DE_SR1_IDX;
  logic [4:0]  DE_SR2_IDX;
  logic [63:0] DE_SR1_DATA;
  logic [63:0] DE_SR2_DATA;
  logic        WB_STALL;
  logic        WB_LD_PC;
  logic [63:0] WB_TARGET_PC;
  logic        TRAP_REQ;
  logic [63:0] TRAP_EPC;
  logic [63:0] INSTRET;

  modport master (
    output WB_V, WB_IR, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_CSRFD,
           WB_PC_MUX, WB_ECALL, DE_SR1_IDX, DE_SR2_IDX,
    input  DE_SR1_DATA, DE_SR2_DATA, WB_STALL, WB_LD_PC, WB_TARGET_PC,
           TRAP_REQ, TRAP_EPC, INSTRET
  );

  modport slave (
    input  WB_V, WB_IR, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_CSRFD,
           WB_PC_MUX, WB_ECALL, DE_SR1_IDX, DE_SR2_IDX,
    output DE_SR1_DATA, DE_SR2_DATA, WB_STALL, WB_LD_PC, WB_TARGET_PC,
           TRAP_REQ, TRAP_EPC, INSTRET
  );
endinterface

// File: rtl/writeback_stage.sv
// RV64 writeback stage: result select with load extension, bypassed 32x64
// register file, branch/jump redirect, retire counter and ECALL trap sequencer.
module writeback_stage #(
  parameter int unsigned TRAP_CYCLES = 3
) (
  input logic              CLK,
  input logic              RESET,
  writeback_stage_if.slave wb
);
  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  localparam int unsigned     CNT_W    = (TRAP_CYCLES > 1) ? $clog2(TRAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TRAP_CYCLES - 1);

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [63:0]      rf_r [0:31];
  logic [63:0]      instret_r;
  logic [63:0]      trap_epc_r;
  logic             trap_req_r;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rd_s;
  logic [63:0] result_s;
  logic [63:0] mem_s;
  logic        writes_s;
  logic        retire_s;
  logic        rf_we_s;
  logic        stall_s;
  logic        trap_start_s;
  logic [63:0] sr1_s, sr2_s;

  assign opcode_s = wb.WB_IR[6:0];
  assign funct3_s = wb.WB_IR[14:12];
  assign rd_s     = wb.WB_IR[11:7];
  assign mem_s    = wb.WB_MEM_RESULT;
  assign retire_s = wb.WB_V && (state_r == IDLE);
  assign rf_we_s  = retire_s && writes_s && (rd_s != 5'd0);

  // Result selection and write-enable decode by opcode.
  always_comb begin
    result_s = 64'd0;
    writes_s = 1'b0;
    case (opcode_s)
      7'b0000011: begin
        writes_s = 1'b1;
        case (funct3_s)
          3'b000:  result_s = {{56{mem_s[7]}}, mem_s[7:0]};
          3'b001:  result_s = {{48{mem_s[15]}}, mem_s[15:0]};
          3'b010:  result_s = {{32{mem_s[31]}}, mem_s[31:0]};
          3'b011:  result_s = mem_s;
          3'b100:  result_s = {56'd0, mem_s[7:0]};
          3'b101:  result_s = {48'd0, mem_s[15:0]};
          3'b110:  result_s = {32'd0, mem_s[31:0]};
          default: result_s = 64'd0;
        endcase
      end
      7'b1101111, 7'b1100111: begin
        writes_s = 1'b1;
        result_s = wb.WB_NPC;
      end
      7'b1110011: begin
        if (funct3_s != 3'b000) begin
          writes_s = 1'b1;
          result_s = wb.WB_CSRFD;
        end else begin
          writes_s = 1'b0;
          result_s = 64'd0;
        end
      end
      7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011, 7'b0011011, 7'b0111011: begin
        writes_s = 1'b1;
        result_s = wb.WB_ALU_RESULT;
      end
      default: begin
        writes_s = 1'b0;
        result_s = 64'd0;
      end
    endcase
  end

  // Decode read ports with same-cycle bypass of the retiring write.
  always_comb begin
    sr1_s = 64'd0;
    sr2_s = 64'd0;
    if (wb.DE_SR1_IDX == 5'd0) begin
      sr1_s = 64'd0;
    end else if (rf_we_s && (wb.DE_SR1_IDX == rd_s)) begin
      sr1_s = result_s;
    end else begin
      sr1_s = rf_r[wb.DE_SR1_IDX];
    end
    if (wb.DE_SR2_IDX == 5'd0) begin
      sr2_s = 64'd0;
    end else if (rf_we_s && (wb.DE_SR2_IDX == rd_s)) begin
      sr2_s = result_s;
    end else begin
      sr2_s = rf_r[wb.DE_SR2_IDX];
    end
  end

  // Trap sequencer next state; stall covers the ECALL cycle plus cnt!=0 drain cycles.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    stall_s      = 1'b0;
    trap_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (wb.WB_V && wb.WB_ECALL) begin
          stall_s      = 1'b1;
          trap_start_s = 1'b1;
          state_next_s = DRAIN;
          cnt_next_s   = CNT_INIT;
        end else begin
          stall_s      = 1'b0;
          trap_start_s = 1'b0;
        end
      end
      DRAIN: begin
        stall_s = (cnt_r != {CNT_W{1'b0}});
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_next_s = cnt_r - CNT_W'(1);
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Trap state, trap outputs and retired-instruction counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      trap_req_r <= 1'b0;
      trap_epc_r <= 64'd0;
      instret_r  <= 64'd0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      trap_req_r <= trap_start_s;
      if (trap_start_s) begin
        trap_epc_r <= wb.WB_NPC - 64'd4;
      end
      if (retire_s) begin
        instret_r <= instret_r + 64'd1;
      end
    end
  end

  // Register file array; entry 0 is never written so it stays zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) begin
        rf_r[i] <= 64'd0;
      end
    end else if (rf_we_s) begin
      rf_r[rd_s] <= result_s;
    end
  end

  assign wb.DE_SR1_DATA  = sr1_s;
  assign wb.DE_SR2_DATA  = sr2_s;
  assign wb.WB_STALL     = stall_s;
  assign wb.WB_LD_PC     = retire_s && wb.WB_PC_MUX;
  assign wb.WB_TARGET_PC = (opcode_s == 7'b1100111) ? {wb.WB_ALU_RESULT[63:1], 1'b0}
                                                    : wb.WB_ALU_RESULT;
  assign wb.TRAP_REQ     = trap_req_r;
  assign wb.TRAP_EPC     = trap_epc_r;
  assign wb.INSTRET      = instret_r;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage with TRAP_CYCLES=3.
module tb_writeback_stage;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [63:0] exp_instret;

  writeback_stage_if bus();

  writeback_stage #(.TRAP_CYCLES(3)) dut (
    .CLK   (clk),
    .RESET (rst),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, op};
  endfunction

  task automatic idle_bus();
    bus.WB_V          = 1'b0;
    bus.WB_IR         = 32'd0;
    bus.WB_NPC        = 64'd0;
    bus.WB_ALU_RESULT = 64'd0;
    bus.WB_MEM_RESULT = 64'd0;
    bus.WB_CSRFD      = 64'd0;
    bus.WB_PC_MUX     = 1'b0;
    bus.WB_ECALL      = 1'b0;
    bus.DE_SR1_IDX    = 5'd0;
    bus.DE_SR2_IDX    = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    bus.DE_SR1_IDX = 5'd5;
    bus.DE_SR2_IDX = 5'd31;
    step();
    step();
    rst = 1'b0;
    #1;
    exp_instret = 64'd0;
    checks++; if (bus.INSTRET !== 64'd0) begin failures++; $display("FAIL reset_instret got %h want 0", bus.INSTRET); end
    checks++; if (bus.TRAP_REQ !== 1'b0) begin failures++; $display("FAIL reset_trap_req got %b want 0", bus.TRAP_REQ); end
    checks++; if (bus.TRAP_EPC !== 64'd0) begin failures++; $display("FAIL reset_trap_epc got %h want 0", bus.TRAP_EPC); end
    checks++; if (bus.WB_STALL !== 1'b0 || bus.WB_LD_PC !== 1'b0) begin failures++; $display("FAIL reset_ctrl got stall=%b ldpc=%b want 0/0", bus.WB_STALL, bus.WB_LD_PC); end
    checks++; if (bus.DE_SR1_DATA !== 64'd0 || bus.DE_SR2_DATA !== 64'd0) begin failures++; $display("FAIL reset_rf got %h/%h want 0/0", bus.DE_SR1_DATA, bus.DE_SR2_DATA); end
  endtask

  task automatic test_addi();
    idle_bus();
    bus.WB_V = 1'b1;
    bus.WB_IR = mk_ir(7'b0010011, 3'b000, 5'd5);
    bus.WB_ALU_RESULT = 64'h1234;
    bus.DE_SR1_IDX = 5'd5;
    bus.DE_SR2_IDX = 5'd5;
    #1;
    checks++; if (bus.DE_SR1_DATA !== 64'h1234) begin failures++; $display("FAIL addi_bypass_sr1 got %h want 1234", bus.DE_SR1_DATA); end
    checks++; if (bus.DE_SR2_DATA !== 64'h1234) begin failures++; $display("FAIL addi_bypass_sr2 got %h want 1234", bus.DE_SR2_DATA); end
    step();
    exp_instret = exp_instret + 64'd1;
    bus.WB_V = 1'b0;
    #1;
    checks++; if (bus.DE_SR1_DATA !== 64'h1234) begin failures++; $display("FAIL addi_array got %h want 1234", bus.DE_SR1_DATA); end
    checks++; if (bus.INSTRET !== exp_instret) begin failures++; $display("FAIL addi_instret got %h want %h", bus.INSTRET, exp_instret); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [7];
    logic [63:0] mem [7];
    logic [63:0] exp [7];
    f3[0] = 3'b000; mem[0] = 64'hAAAA_AAAA_AAAA_AA80; exp[0] = 64'hFFFF_FFFF_FFFF_FF80;
    f3[1] = 3'b100; mem[1] = 64'hAAAA_AAAA_AAAA_AA80; exp[1] = 64'h0000_0000_0000_0080;
    f3[2] = 3'b010; mem[2] = 64'h5555_5555_8000_0000; exp[2] = 64'hFFFF_FFFF_8000_0000;
    f3[3] = 3'b110; mem[3] = 64'h5555_5555_8000_0000; exp[3] = 64'h0000_0000_8000_0000;
    f3[4] = 3'b001; mem[4] = 64'h1234_5678_9ABC_8001; exp[4] = 64'hFFFF_FFFF_FFFF_8001;
    f3[5] = 3'b101; mem[5] = 64'h1234_5678_9ABC_8001; exp[5] = 64'h0000_0000_0000_8001;
    f3[6] = 3'b011; mem[6] = 64'h8765_4321_0FED_CBA9; exp[6] = 64'h8765_4321_0FED_CBA9;
    for (int i = 0; i < 7; i++) begin
      idle_bus();
      bus.WB_V = 1'b1;
      bus.WB_IR = mk_ir(7'b0000011, f3[i], 5'd6);
      bus.WB_MEM_RESULT = mem[i];
      bus.WB_ALU_RESULT = 64'hDEAD_BEEF;
      bus.DE_SR2_IDX = 5'd6;
      #1;
      checks++; if (bus.DE_SR2_DATA !== exp[i]) begin failures++; $display("FAIL load_f3_%0d got %h want %h", f3[i], bus.DE_SR2_DATA, exp[i]); end
      step();
      exp_instret = exp_instret + 64'd1;
    end
    idle_bus();
    bus.DE_SR2_IDX = 5'd6;
    #1;
    checks++; if (bus.DE_SR2_DATA !== exp[6]) begin failures++; $display("FAIL load_array got %h want %h", bus.DE_SR2_DATA, exp[6]); end
    checks++; if (bus.INSTRET !== exp_instret) begin failures++; $display("FAIL load_instret got %h want %h", bus.INSTRET, exp_instret); end
  endtask

  task automatic test_x0();
    idle_bus();
    bus.WB_V = 1'b1;
    bus.WB_IR = mk_ir(7'b0010011, 3'b000, 5'd0);
    bus.WB_ALU_RESULT = 64'hDEAD;
    #1;
    checks++; if (bus.DE_SR1_DATA !== 64'd0) begin failures++; $display("FAIL x0_bypass got %h want 0", bus.DE_SR1_DATA); end
    step();
    exp_instret = exp_instret + 64'd1;
    bus.WB_V = 1'b0;
    #1;
    checks++; if (bus.DE_SR1_DATA !== 64'd0) begin failures++; $display("FAIL x0_array got %h want 0", bus.DE_SR1_DATA); end
    checks++; if (bus.INSTRET !== exp_instret) begin failures++; $display("FAIL x0_instret got %h want %h", bus.INSTRET, exp_instret); end
  endtask

  task automatic test_jalr();
    idle_bus();
    bus.WB_V = 1'b1;
    bus.WB_IR = mk_ir(7'b1100111, 3'b000, 5'd1);
    bus.WB_PC_MUX = 1'b1;
    bus.WB_ALU_RESULT = 64'h1001;
    bus.WB_NPC = 64'h2004;
    bus.DE_SR1_IDX = 5'd1;
    #1;
    checks++; if (bus.WB_LD_PC !== 1'b1) begin failures++; $display("FAIL jalr_ldpc got %b want 1", bus.WB_LD_PC); end
    checks++; if (bus.WB_TARGET_PC !== 64'h1000) begin failures++; $display("FAIL jalr_target got %h want 1000", bus.WB_TARGET_PC); end
    checks++; if (bus.DE_SR1_DATA !== 64'h2004) begin failures++; $display("FAIL jalr_link got %h want 2004", bus.DE_SR1_DATA); end
    step();
    exp_instret = exp_instret + 64'd1;
    // Same JALR (plus a held ECALL flag) with WB_V low must do nothing.
    bus.WB_V = 1'b0;
    bus.WB_NPC = 64'h3004;
    bus.WB_ECALL = 1'b1;
    #1;
    checks++; if (bus.WB_LD_PC !== 1'b0 || bus.WB_STALL !== 1'b0) begin failures++; $display("FAIL invalid_ctrl got ldpc=%b stall=%b want 0/0", bus.WB_LD_PC, bus.WB_STALL); end
    step();
    checks++; if (bus.DE_SR1_DATA !== 64'h2004) begin failures++; $display("FAIL invalid_nowrite got %h want 2004", bus.DE_SR1_DATA); end
    checks++; if (bus.INSTRET !== exp_instret || bus.TRAP_REQ !== 1'b0) begin failures++; $display("FAIL invalid_count got %h req=%b want %h req=0", bus.INSTRET, bus.TRAP_REQ, exp_instret); end
  endtask

  task automatic test_csr_branch();
    idle_bus();
    bus.WB_V = 1'b1;
    bus.WB_IR = mk_ir(7'b1110011, 3'b001, 5'd10);
    bus.WB_CSRFD = 64'hC5C5;
    bus.WB_ALU_RESULT = 64'h9999;
    bus.DE_SR1_IDX = 5'd10;
    #1;
    checks++; if (bus.DE_SR1_DATA !== 64'hC5C5) begin failures++; $display("FAIL csr_result got %h want c5c5", bus.DE_SR1_DATA); end
    step();
    exp_instret = exp_instret + 64'd1;
    bus.WB_IR = mk_ir(7'b1100011, 3'b000, 5'd10);
    bus.WB_PC_MUX = 1'b1;
    bus.WB_ALU_RESULT = 64'h2001;
    #1;
    checks++; if (bus.WB_LD_PC !== 1'b1 || bus.WB_TARGET_PC !== 64'h2001) begin failures++; $display("FAIL branch_redirect got ldpc=%b tgt=%h want 1/2001", bus.WB_LD_PC, bus.WB_TARGET_PC); end
    step();
    exp_instret = exp_instret + 64'd1;
    bus.WB_V = 1'b0;
    #1;
    checks++; if (bus.DE_SR1_DATA !== 64'hC5C5) begin failures++; $display("FAIL branch_nowrite got %h want c5c5", bus.DE_SR1_DATA); end
  endtask

  task automatic test_ecall();
    int   stall_cnt;
    int   req_cnt;
    logic exp_stall;
    logic exp_req;
    stall_cnt = 0;
    req_cnt = 0;
    idle_bus();
    bus.WB_V = 1'b1;
    bus.WB_IR = 32'h0000_0073;
    bus.WB_ECALL = 1'b1;
    bus.WB_NPC = 64'h104;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_stall = (k < 3);
      checks++; if (bus.WB_STALL !== exp_stall) begin failures++; $display("FAIL ecall_stall_c%0d got %b want %b", k, bus.WB_STALL, exp_stall); end
      if (bus.WB_STALL === 1'b1) stall_cnt++;
      step();
      exp_req = (k == 0);
      if (bus.TRAP_REQ === 1'b1) req_cnt++;
      checks++; if (bus.TRAP_REQ !== exp_req) begin failures++; $display("FAIL ecall_req_c%0d got %b want %b", k, bus.TRAP_REQ, exp_req); end
      if (k == 0) begin
        checks++; if (bus.TRAP_EPC !== 64'h100) begin failures++; $display("FAIL ecall_epc got %h want 100", bus.TRAP_EPC); end
      end
    end
    exp_instret = exp_instret + 64'd1;
    checks++; if (stall_cnt != 3 || req_cnt != 1) begin failures++; $display("FAIL ecall_counts got stall=%0d req=%0d want 3/1", stall_cnt, req_cnt); end
    checks++; if (bus.INSTRET !== exp_instret) begin failures++; $display("FAIL ecall_instret got %h want %h", bus.INSTRET, exp_instret); end
    // Follow-on instruction retires immediately after the drain.
    bus.WB_ECALL = 1'b0;
    bus.WB_IR = mk_ir(7'b0010011, 3'b000, 5'd7);
    bus.WB_ALU_RESULT = 64'h77;
    bus.DE_SR1_IDX = 5'd7;
    #1;
    checks++; if (bus.WB_STALL !== 1'b0 || bus.DE_SR1_DATA !== 64'h77) begin failures++; $display("FAIL after_ecall got stall=%b data=%h want 0/77", bus.WB_STALL, bus.DE_SR1_DATA); end
    step();
    exp_instret = exp_instret + 64'd1;
    checks++; if (bus.INSTRET !== exp_instret) begin failures++; $display("FAIL after_ecall_instret got %h want %h", bus.INSTRET, exp_instret); end
  endtask

  task automatic test_reset_mid_drain();
    idle_bus();
    bus.WB_V = 1'b1;
    bus.WB_IR = 32'h0000_0073;
    bus.WB_ECALL = 1'b1;
    bus.WB_NPC = 64'h204;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_bus();
    bus.DE_SR1_IDX = 5'd5;
    exp_instret = 64'd0;
    #1;
    checks++; if (bus.WB_STALL !== 1'b0 || bus.TRAP_REQ !== 1'b0) begin failures++; $display("FAIL rst_drain_ctrl got stall=%b req=%b want 0/0", bus.WB_STALL, bus.TRAP_REQ); end
    checks++; if (bus.INSTRET !== 64'd0) begin failures++; $display("FAIL rst_drain_instret got %h want 0", bus.INSTRET); end
    checks++; if (bus.DE_SR1_DATA !== 64'd0) begin failures++; $display("FAIL rst_drain_x5 got %h want 0", bus.DE_SR1_DATA); end
    bus.WB_V = 1'b1;
    bus.WB_IR = mk_ir(7'b0010011, 3'b000, 5'd8);
    bus.WB_ALU_RESULT = 64'h88;
    bus.DE_SR1_IDX = 5'd8;
    #1;
    checks++; if (bus.DE_SR1_DATA !== 64'h88) begin failures++; $display("FAIL rst_drain_idle got %h want 88", bus.DE_SR1_DATA); end
    step();
    exp_instret = exp_instret + 64'd1;
    checks++; if (bus.INSTRET !== exp_instret) begin failures++; $display("FAIL rst_drain_retire got %h want %h", bus.INSTRET, exp_instret); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_instret = 64'd0;
    rst = 1'b1;
    idle_bus();
    test_reset();
    test_addi();
    test_loads();
    test_x0();
    test_jalr();
    test_csr_branch();
    test_ecall();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
